// File: rtl/tt_um_algofoogle_count_checker_pkg.sv
// Shared types and constants for the counter-sequence checker.
// Holds the FSM encoding, default thresholds and error-count width.
package tt_um_algofoogle_count_checker_pkg;

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int LOCK_COUNT_DEF = 4;
  localparam int LOSS_COUNT_DEF = 3;
  localparam int ERR_W          = 16;
  localparam int RUN_W          = 8;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef struct packed {
    logic [3:0] nib;
    logic       val;
    logic       clr;
  } s0_t;

  function automatic logic [3:0] next_nib(input logic [3:0] n);
    return n + 4'd1;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating up-counter with clear taking priority.
// Used as the checker's mismatch counter.
module sat_counter16
  import tt_um_algofoogle_count_checker_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] count,
  output logic             sat
);

  assign sat = (count == ERR_MAX);

  // clear beats increment; hold at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_algofoogle_count_checker.sv
// Checks an incrementing 4-bit counter stream for continuity.
// Locks after a run of good steps, counts errors while locked.
module tt_um_algofoogle_count_checker
  import tt_um_algofoogle_count_checker_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [RUN_W-1:0] LOCK_N = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOSS_N = RUN_W'(LOSS_COUNT);

  s0_t              s0;
  logic [0:0]       state;
  logic [3:0]       prev;
  logic             have_prev;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;
  logic             lost_sticky;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             err_sat;

  logic             cmp;
  logic             match;
  logic             miss;
  logic             err_inc;
  logic             loss;
  logic             lock_hit;

  logic             unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7]};

  // input capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= '0;
    end else begin
      s0.nib <= ui_in[3:0];
      s0.val <= ui_in[4];
      s0.clr <= ui_in[5];
    end
  end

  // compare decode for the sample held in s0
  always_comb begin
    cmp      = s0.val && have_prev;
    match    = (s0.nib == next_nib(prev));
    miss     = cmp && !match;
    err_inc  = miss && (state == LOCKED);
    loss     = err_inc && ((bad_run + 1'b1) == LOSS_N);
    lock_hit = cmp && match && (state == HUNT)
               && ((good_run + 1'b1) == LOCK_N);
  end

  // last accepted nibble and its validity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (s0.val) begin
      prev <= s0.nib;
      if (!have_prev) begin
        have_prev <= 1'b1;
      end else if (loss) begin
        have_prev <= 1'b0;
      end
    end
  end

  // hunt/lock state machine with run counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      good_run <= '0;
      bad_run  <= '0;
    end else if (cmp) begin
      unique case (state)
        HUNT: begin
          if (lock_hit) begin
            state    <= LOCKED;
            good_run <= '0;
          end else if (match) begin
            good_run <= good_run + 1'b1;
          end else begin
            good_run <= '0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_run <= '0;
          end else if (loss) begin
            state   <= HUNT;
            bad_run <= '0;
          end else begin
            bad_run <= bad_run + 1'b1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // one-cycle error strobe and sticky loss flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse   <= 1'b0;
      lost_sticky <= 1'b0;
    end else begin
      err_pulse <= err_inc;
      if (s0.clr) begin
        lost_sticky <= 1'b0;
      end else if (loss) begin
        lost_sticky <= 1'b1;
      end
    end
  end

  sat_counter16 u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (s0.clr),
    .count (err_count),
    .sat   (err_sat)
  );

  assign uo_out  = {prev, err_sat, err_pulse,
                    lost_sticky, state};
  assign uio_out = ui_in[6] ? err_count[15:8]
                            : err_count[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: doc/tt_um_algofoogle_count_checker.md
TT_UM_ALGOFOOGLE_COUNT_CHECKER -- requirements
Module: tt_um_algofoogle_count_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive good increments needed to lock.
REQ-002 SHALL have parameter LOSS_COUNT, default 3: consecutive mismatches while locked that force loss of lock.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port ena  input  1: ignored.
REQ-006 SHALL have port ui_in  input  8: [3:0] received counter nibble; [4] sample valid; [5] clear errors; [6] uio_out byte select; [7] unused.
REQ-007 SHALL have port uo_out  output  8: [0] locked; [1] lost_sticky; [2] err_pulse; [3] err_sat; [7:4] last accepted nibble.
REQ-008 SHALL have port uio_in  input  8: ignored.
REQ-009 SHALL have port uio_out  output  8: err_count[15:8] when ui_in[6]=1, else err_count[7:0]; combinational mux of registered count.
REQ-010 SHALL have port uio_oe  output  8: constant 8'hFF.

Function
REQ-011 Stage S0 SHALL register ui_in[5:0] every cycle into nib_q, val_q, clr_q.
REQ-012 Stage S1 SHALL act only when val_q=1; when val_q=0, all check state, counters and prev SHALL hold.
REQ-013 First valid sample after reset or loss of lock SHALL load prev=nib_q, set have_prev, perform no compare.
REQ-014 Subsequent valid samples SHALL compute match = (nib_q == prev+1 mod 16), 4-bit wrap (F->0 is a match), then load prev=nib_q.
REQ-015 FSM states HUNT, LOCKED; reset state HUNT.
REQ-016 HUNT: match increments good_run; good_run reaching LOCK_COUNT SHALL move to LOCKED and clear good_run; mismatch clears good_run; no errors counted.
REQ-017 LOCKED: mismatch SHALL increment err_count (16-bit, saturating at 16'hFFFF), increment bad_run, pulse err_pulse for exactly one cycle; match clears bad_run.
REQ-018 bad_run reaching LOSS_COUNT SHALL move to HUNT, set lost_sticky, clear bad_run and have_prev.
REQ-019 err_sat SHALL be 1 exactly when err_count==16'hFFFF.
REQ-020 clr_q=1 SHALL clear err_count and lost_sticky without affecting FSM state, prev or runs; clear wins over a coincident increment or loss.
REQ-021 Latency: a nibble applied on ui_in before edge n SHALL affect locked, err_pulse, err_count and uo_out[7:4] at edge n+1 (2-edge latency).

Reset
REQ-022 rst_n=0 SHALL immediately force: state HUNT, prev=0, have_prev=0, good_run=0, bad_run=0, err_count=0, lost_sticky=0, err_pulse=0, S0 registers 0; hence uo_out=8'h00, uio_out=8'h00.
REQ-023 Reset asserted mid-lock SHALL discard all progress; after release, checking restarts at REQ-013.

Structure
REQ-024 Shared package SHALL hold the state encoding (HUNT=0, LOCKED=1), default LOCK_COUNT/LOSS_COUNT and err_count width 16.
REQ-025 Saturating error counter SHALL be one sub-module, sat_counter16 (inc, clr, clr priority, count, sat outputs).
REQ-026 All outputs SHALL derive from registers, except uio_out byte mux.

Verification
REQ-027 Reset, then nibbles 0,1,2,3,4 valid on consecutive cycles -> locked=1 two edges after nibble 4 applied; err_count=0.
REQ-028 Locked, then sequence E,F,0,1 -> wrap accepted; locked stays 1; err_pulse never asserted.
REQ-029 Locked, then one bad nibble (5,6,9,A) -> err_pulse one cycle, err_count=1, locked stays 1.
REQ-030 Locked, then 3 consecutive mismatches -> err_count=3, locked=0, lost_sticky=1; clear pulse -> err_count=0, lost_sticky=0, locked still 0.
REQ-031 Preload err_count=16'hFFFE, 2 mismatches -> uio_out=8'hFF for both ui_in[6]=0/1, err_sat=1; clear coincident with mismatch -> err_count=0.
REQ-032 Valid gaps (val=0 between nibbles 3 and 4) -> no mismatch; rst_n pulsed while locked -> uo_out=8'h00 immediately.
